icache_refill_ctrl: RTL and testbench
=====================================

ICACHE_REFILL_CTRL -- requirements
Module: icache_refill_ctrl

Interface
REQ-001 SHALL provide parameter LINES, default 32, number of one-word lines (power of two, 2..256).
REQ-002 SHALL provide parameter IDX_W, default 5, index width = log2(LINES).
REQ-003 SHALL provide port clock  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL provide port fetch_valid  input  1  fetch request present.
REQ-006 SHALL provide port fetch_addr  input  32  byte address; index = [IDX_W+1:2], tag = [31:IDX_W+2].
REQ-007 SHALL provide port flush  input  1  invalidate all lines.
REQ-008 SHALL provide port instr  output  32  instruction word, meaningful only when hit=1.
REQ-009 SHALL provide port hit  output  1  instr valid this cycle.
REQ-010 SHALL provide port stall  output  1  fetch must hold fetch_addr stable.
REQ-011 SHALL provide port mem_req  output  1  backing-memory read request.
REQ-012 SHALL provide port mem_addr  output  32  word-aligned read address.
REQ-013 SHALL provide port mem_ack  input  1  mem_rdata valid, request accepted.
REQ-014 SHALL provide port mem_rdata  input  32  refill data.

Function
REQ-015 SHALL hold per line: data (32), tag (32-IDX_W-2), valid (1).
REQ-016 SHALL implement FSM states IDLE, REFILL.
REQ-017 In IDLE, hit SHALL be combinational: fetch_valid & valid[idx] & tag match & !flush; instr = data[idx] same cycle.
REQ-018 In IDLE, fetch_valid & !hit & !flush SHALL assert stall same cycle, latch {fetch_addr[31:2],2'b00} into mem_addr, and enter REFILL next edge.
REQ-019 In REFILL, mem_req=1, stall=1, hit=0, mem_addr constant until the mem_ack cycle inclusive.
REQ-020 On mem_ack in REFILL, SHALL write mem_rdata, tag, valid=1 to the latched index at that edge, deassert mem_req next cycle, return to IDLE.
REQ-021 Refill-to-hit latency SHALL be: miss cycle N, mem_req from N+1, ack at cycle M, hit at M+1 (minimum 2 cycles miss-to-hit).
REQ-022 mem_ack outside REFILL SHALL be ignored.
REQ-023 flush in IDLE SHALL clear all valid bits at the next edge; hit=0 and no refill is started that cycle.
REQ-024 flush in REFILL SHALL clear all valid bits and set flush_pend; if flush or flush_pend on the ack cycle, line written with valid=0, flush_pend cleared, FSM returns to IDLE.
REQ-025 Index wrap: idx 31 and idx 0 SHALL be independent; same index different tag SHALL replace (direct-mapped).
REQ-026 fetch_valid=0 in IDLE SHALL produce hit=0, stall=0, no state change.

Reset
REQ-027 reset SHALL force IDLE, all valid=0, flush_pend=0, mem_req=0, mem_addr=0, stall=0, hit=0, instr=0 asynchronously.
REQ-028 reset mid-REFILL SHALL abandon the request immediately; a later mem_ack SHALL write nothing.
REQ-029 Data and tag arrays SHALL need no reset.

Configuration
REQ-030 Macro ICACHE_PERF_CNT_EN defined: SHALL add outputs hit_count (32) and miss_count (32), incremented on each hit cycle / each IDLE->REFILL transition, wrap at 2^32, cleared by reset only.
REQ-031 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-032 Cold miss: reset, fetch addr 0x0000_0010, ack after 3 cycles data 0x0010_0093 -> mem_addr 0x10, stall 4 cycles, then hit=1 instr=0x0010_0093.
REQ-033 Conflict: fill 0x0000_0000 then fetch 0x0000_0080 (same idx 0) -> miss, refill; re-fetch 0x0 -> miss again.
REQ-034 Flush mid-refill: flush during REFILL for 0x40, ack 0xDEAD_BEEF -> next fetch 0x40 misses; all prior lines miss.
REQ-035 Reset mid-refill: reset asserted in REFILL, then spurious mem_ack -> mem_req=0 immediately, fetch of that address misses.
REQ-036 Back-to-back hits to idx 0 and 31 (0x00, 0x7C) after fill -> hit=1 every cycle, stall=0, mem_req=0.
REQ-037 With ICACHE_PERF_CNT_EN: 3 misses + 5 hits -> miss_count=3, hit_count=5.

Source files
------------

// File: rtl/icache_refill_ctrl.sv
// Direct-mapped, one-word-per-line instruction cache refill controller.
// Optional hit/miss counters are enabled by defining ICACHE_PERF_CNT_EN.
module icache_refill_ctrl #(
  parameter int LINES = 32,
  parameter int IDX_W = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_addr,
  input  logic        flush,
  output logic [31:0] instr,
  output logic        hit,
  output logic        stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int TAG_W = 32 - IDX_W - 2;

  typedef enum logic {IDLE, REFILL} state_t;

  state_t             state_q, state_d;
  logic               mem_req_q, mem_req_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic               flush_pend_q, flush_pend_d;
  logic [LINES-1:0]   valid_q, valid_d;
  logic [31:0]        data_q [LINES];
  logic [TAG_W-1:0]   tag_q  [LINES];

  logic [IDX_W-1:0]   f_idx, r_idx;
  logic [TAG_W-1:0]   f_tag, r_tag;
  logic               lookup_hit;
  logic               refill_we;
  logic               miss;
  logic [1:0]         unused_addr_lsb;

  assign f_idx           = fetch_addr[IDX_W+1:2];
  assign f_tag           = fetch_addr[31:IDX_W+2];
  assign r_idx           = mem_addr_q[IDX_W+1:2];
  assign r_tag           = mem_addr_q[31:IDX_W+2];
  assign unused_addr_lsb = fetch_addr[1:0];

  assign lookup_hit = (state_q == IDLE) && fetch_valid && !flush &&
                      valid_q[f_idx] && (tag_q[f_idx] == f_tag);

  assign hit      = lookup_hit;
  assign instr    = lookup_hit ? data_q[f_idx] : 32'h0;
  assign stall    = (state_q == REFILL) || (fetch_valid && !lookup_hit);
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    flush_pend_d = flush_pend_q;
    valid_d      = valid_q;
    refill_we    = 1'b0;
    miss         = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush) begin
          valid_d = '0;
        end else if (fetch_valid && !lookup_hit) begin
          miss       = 1'b1;
          state_d    = REFILL;
          mem_req_d  = 1'b1;
          mem_addr_d = {fetch_addr[31:2], 2'b00};
        end
      end
      REFILL: begin
        if (flush) valid_d = '0;
        if (mem_ack) begin
          // A flush seen at any point during the refill poisons the returning line.
          refill_we      = 1'b1;
          valid_d[r_idx] = !(flush || flush_pend_q);
          flush_pend_d   = 1'b0;
          mem_req_d      = 1'b0;
          state_d        = IDLE;
        end else if (flush) begin
          flush_pend_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= 32'h0;
      flush_pend_q <= 1'b0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      flush_pend_q <= flush_pend_d;
      valid_q      <= valid_d;
    end
  end

  always_ff @(posedge clock) begin
    if (refill_we) begin
      data_q[r_idx] <= mem_rdata;
      tag_q[r_idx]  <= r_tag;
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_count_q, miss_count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_count_q  <= 32'h0;
      miss_count_q <= 32'h0;
    end else begin
      if (lookup_hit) hit_count_q  <= hit_count_q + 32'd1;
      if (miss)       miss_count_q <= miss_count_q + 32'd1;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Scoreboard bench for icache_refill_ctrl: stimulus pushes expected instr/mem_addr,
// monitors pop and compare when the cache presents hit or raises mem_req.
module tb_icache_refill_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        fetch_valid;
  logic [31:0] fetch_addr;
  logic        flush;
  logic [31:0] instr;
  logic        hit;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_count, miss_count;
`endif

  icache_refill_ctrl #(.LINES(32), .IDX_W(5)) dut (
    .clock       (clock),
    .reset       (reset),
    .fetch_valid (fetch_valid),
    .fetch_addr  (fetch_addr),
    .flush       (flush),
    .instr       (instr),
    .hit         (hit),
    .stall       (stall),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_count   (hit_count),
    .miss_count  (miss_count)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_instr_q [$];
  logic [31:0] exp_addr_q  [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Instruction monitor: every hit cycle consumes one expected word.
  always @(negedge clock) begin
    if (!reset && hit) begin
      if (exp_instr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_hit: got instr %h expected no hit", instr);
      end else begin
        chk("instr", instr, exp_instr_q.pop_front());
      end
      chk("hit_stall", {31'h0, stall}, 32'h0);
      chk("hit_mem_req", {31'h0, mem_req}, 32'h0);
    end
  end

  // Request monitor: each new mem_req consumes one expected address, held until it drops.
  logic        req_prev = 1'b0;
  logic [31:0] cur_addr = 32'h0;
  always @(negedge clock) begin
    if (mem_req && !req_prev) begin
      if (exp_addr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_req: got mem_addr %h expected no request", mem_addr);
      end else begin
        cur_addr = exp_addr_q.pop_front();
        chk("mem_addr", mem_addr, cur_addr);
      end
    end else if (mem_req && req_prev) begin
      chk("mem_addr_hold", mem_addr, cur_addr);
    end
    req_prev = mem_req;
  end

  // One fetch until its hit; on a miss the memory acks on the lat-th request cycle.
  task automatic access(input logic [31:0] a, input bit exp_hit,
                        input logic [31:0] d, input int lat);
    int  cnt;
    int  stalls;
    bit  got;
    exp_instr_q.push_back(d);
    if (!exp_hit) exp_addr_q.push_back({a[31:2], 2'b00});
    @(posedge clock); #1;
    fetch_valid = 1'b1;
    fetch_addr  = a;
    cnt = 0; stalls = 0; got = 1'b0;
    for (int cyc = 0; cyc < 40 && !got; cyc++) begin
      @(negedge clock);
      mem_ack = 1'b0;
      if (hit) begin
        got = 1'b1;
      end else begin
        if (stall) stalls++;
        if (mem_req) cnt++;
        mem_ack   = mem_req && (cnt == lat);
        mem_rdata = d;
      end
    end
    mem_ack = 1'b0;
    chk("hit_seen", {31'h0, got}, 32'h1);
    chk("stall_cycles", stalls, exp_hit ? 32'd0 : 32'(lat + 1));
  endtask

  task automatic idle();
    @(posedge clock); #1;
    fetch_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; fetch_valid = 1'b0; fetch_addr = 32'h0;
    flush = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
    #12;
    chk("rst_hit", {31'h0, hit}, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_instr", instr, 32'h0);
    @(negedge clock); reset = 1'b0;

    // Cold miss: 4 stall cycles with ack on the third request cycle.
    access(32'h0000_0010, 1'b0, 32'h0010_0093, 3);
    access(32'h0000_0010, 1'b1, 32'h0010_0093, 0);

    // Conflict on index 0.
    access(32'h0000_0000, 1'b0, 32'h1111_0000, 1);
    access(32'h0000_0080, 1'b0, 32'h2222_0080, 2);
    access(32'h0000_0000, 1'b0, 32'h3333_0000, 1);

    // Back-to-back hits at index 0 and 31.
    access(32'h0000_007C, 1'b0, 32'h4444_007C, 1);
    access(32'h0000_0000, 1'b1, 32'h3333_0000, 0);
    access(32'h0000_007C, 1'b1, 32'h4444_007C, 0);
    access(32'h0000_0000, 1'b1, 32'h3333_0000, 0);
    access(32'h0000_007C, 1'b1, 32'h4444_007C, 0);

    // fetch_valid low on a resident line: nothing happens.
    @(posedge clock); #1;
    fetch_valid = 1'b0; fetch_addr = 32'h0000_007C;
    @(negedge clock);
    chk("novalid_hit", {31'h0, hit}, 32'h0);
    chk("novalid_stall", {31'h0, stall}, 32'h0);
    @(negedge clock);
    chk("novalid_mem_req", {31'h0, mem_req}, 32'h0);

    // Flush in IDLE on a resident line: no hit, no refill, line gone afterwards.
    @(posedge clock); #1;
    fetch_valid = 1'b1; fetch_addr = 32'h0000_0010; flush = 1'b1;
    @(negedge clock);
    chk("flush_idle_hit", {31'h0, hit}, 32'h0);
    @(posedge clock); #1;
    flush = 1'b0; fetch_valid = 1'b0;
    @(negedge clock);
    chk("flush_idle_mem_req", {31'h0, mem_req}, 32'h0);
    access(32'h0000_0010, 1'b0, 32'h5555_0010, 1);

    // Flush mid-refill: returning line is dropped.
    @(posedge clock); #1;
    fetch_valid = 1'b1; fetch_addr = 32'h0000_0040;
    exp_addr_q.push_back(32'h0000_0040);
    @(posedge clock); #1;
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0; fetch_valid = 1'b0;
    @(negedge clock);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(posedge clock); #1;
    mem_ack = 1'b0;
    @(negedge clock);
    chk("flush_ref_mem_req", {31'h0, mem_req}, 32'h0);
    access(32'h0000_0040, 1'b0, 32'h6666_0040, 1);
    access(32'h0000_0010, 1'b0, 32'h7777_0010, 1);
    access(32'h0000_007C, 1'b0, 32'h8888_007C, 2);

    // Reset mid-refill, then a stray ack.
    @(posedge clock); #1;
    fetch_valid = 1'b1; fetch_addr = 32'h0000_0100;
    exp_addr_q.push_back(32'h0000_0100);
    @(negedge clock);
    @(negedge clock);
    chk("pre_rst_mem_req", {31'h0, mem_req}, 32'h1);
    #1 reset = 1'b1; fetch_valid = 1'b0;
    #1 chk("rst_mid_mem_req", {31'h0, mem_req}, 32'h0);
    @(negedge clock); reset = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    @(posedge clock); #1;
    mem_ack = 1'b0;
    @(negedge clock);
    chk("stray_ack_mem_req", {31'h0, mem_req}, 32'h0);
    access(32'h0000_0100, 1'b0, 32'h9999_0100, 2);
    idle();

`ifdef ICACHE_PERF_CNT_EN
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    chk("cnt_rst_hit", hit_count, 32'h0);
    chk("cnt_rst_miss", miss_count, 32'h0);
    // Each refilled fetch ends in one hit cycle: 3 misses give 3 hits, plus 2 more.
    access(32'h0000_0004, 1'b0, 32'hA000_0004, 1);
    access(32'h0000_0008, 1'b0, 32'hA000_0008, 1);
    access(32'h0000_000C, 1'b0, 32'hA000_000C, 1);
    access(32'h0000_0004, 1'b1, 32'hA000_0004, 0);
    access(32'h0000_0008, 1'b1, 32'hA000_0008, 0);
    idle();
    @(negedge clock);
    chk("miss_count", miss_count, 32'd3);
    chk("hit_count", hit_count, 32'd5);
`endif

    repeat (3) @(negedge clock);
    chk("instr_queue_empty", exp_instr_q.size(), 32'd0);
    chk("addr_queue_empty", exp_addr_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
